// File: rtl/vga_timing_controller.sv
// VGA raster sequencer: one horizontal and one vertical counter with registered
// sync/enable/coordinate/strobe outputs, plus a run/stop FSM that only halts on a frame boundary.
module vga_timing_controller #(
   parameter int H_ACTIVE        = 640,
   parameter int H_FRONT         = 16,
   parameter int H_SYNC          = 96,
   parameter int H_BACK          = 48,
   parameter int V_ACTIVE        = 480,
   parameter int V_FRONT         = 10,
   parameter int V_SYNC          = 2,
   parameter int V_BACK          = 33,
   parameter int H_COUNTER_SIZE  = 11,
   parameter int V_COUNTER_SIZE  = 10,
   parameter int SYNC_ACTIVE_LOW = 1
) (
   input  logic                      control_clock,
   input  logic                      reset,
   input  logic                      pixel_ce,
   input  logic                      enable,
   output logic                      h_sync,
   output logic                      v_sync,
   output logic                      display_enable,
   output logic [H_COUNTER_SIZE-1:0] pixel_x,
   output logic [V_COUNTER_SIZE-1:0] pixel_y,
   output logic                      line_start,
   output logic                      frame_start,
   output logic                      running
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [H_COUNTER_SIZE-1:0] H_LAST     = H_COUNTER_SIZE'(H_TOTAL - 1);
   localparam logic [H_COUNTER_SIZE-1:0] H_ACT_END  = H_COUNTER_SIZE'(H_ACTIVE);
   localparam logic [H_COUNTER_SIZE-1:0] H_SYNC_BEG = H_COUNTER_SIZE'(H_ACTIVE + H_FRONT);
   localparam logic [H_COUNTER_SIZE-1:0] H_SYNC_END = H_COUNTER_SIZE'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [V_COUNTER_SIZE-1:0] V_LAST     = V_COUNTER_SIZE'(V_TOTAL - 1);
   localparam logic [V_COUNTER_SIZE-1:0] V_ACT_END  = V_COUNTER_SIZE'(V_ACTIVE);
   localparam logic [V_COUNTER_SIZE-1:0] V_SYNC_BEG = V_COUNTER_SIZE'(V_ACTIVE + V_FRONT);
   localparam logic [V_COUNTER_SIZE-1:0] V_SYNC_END = V_COUNTER_SIZE'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic                      SYNC_IDLE  = (SYNC_ACTIVE_LOW != 0);

   typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

   state_t                      state, state_next;
   logic                        step;
   logic [H_COUNTER_SIZE-1:0]   h_next;
   logic [V_COUNTER_SIZE-1:0]   v_next;
   logic                        ls_next, fs_next, run_next;
   logic                        hs_act, vs_act, de_next;

   always_comb begin
      state_next = state;
      step       = 1'b0;
      h_next     = pixel_x;
      v_next     = pixel_y;
      ls_next    = 1'b0;
      fs_next    = 1'b0;

      case (state)
         IDLE: begin
            // First scanned position is (0,0) itself, so the counters do not move here
            if (enable && pixel_ce) begin
               state_next = RUN;
               ls_next    = 1'b1;
               fs_next    = 1'b1;
            end
         end
         RUN: begin
            step = pixel_ce;
            if (!enable) state_next = STOPPING;
         end
         STOPPING: begin
            if (enable) begin
               state_next = RUN;
               step       = pixel_ce;
            end else if (pixel_ce && pixel_x == H_LAST && pixel_y == V_LAST) begin
               state_next = IDLE;
               h_next     = '0;
               v_next     = '0;
            end else begin
               step = pixel_ce;
            end
         end
         default: state_next = IDLE;
      endcase

      if (step) begin
         if (pixel_x == H_LAST) begin
            h_next  = '0;
            ls_next = 1'b1;
            if (pixel_y == V_LAST) begin
               v_next  = '0;
               fs_next = 1'b1;
            end else begin
               v_next = pixel_y + 1'b1;
            end
         end else begin
            h_next = pixel_x + 1'b1;
         end
      end

      // Decode from the next counts so outputs land in the same cycle as their coordinates
      run_next = (state_next != IDLE);
      hs_act   = run_next && (h_next >= H_SYNC_BEG) && (h_next < H_SYNC_END);
      vs_act   = run_next && (v_next >= V_SYNC_BEG) && (v_next < V_SYNC_END);
      de_next  = run_next && (h_next < H_ACT_END) && (v_next < V_ACT_END);
   end

   always_ff @(posedge control_clock) begin
      if (reset) begin
         state          <= IDLE;
         pixel_x        <= '0;
         pixel_y        <= '0;
         h_sync         <= SYNC_IDLE;
         v_sync         <= SYNC_IDLE;
         display_enable <= 1'b0;
         line_start     <= 1'b0;
         frame_start    <= 1'b0;
         running        <= 1'b0;
      end else begin
         state          <= state_next;
         pixel_x        <= h_next;
         pixel_y        <= v_next;
         h_sync         <= hs_act ? ~SYNC_IDLE : SYNC_IDLE;
         v_sync         <= vs_act ? ~SYNC_IDLE : SYNC_IDLE;
         display_enable <= de_next;
         line_start     <= ls_next;
         frame_start    <= fs_next;
         running        <= run_next;
      end
   end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller on a shrunken raster (15 x 10) so whole frames fit in a short run;
// a second instance checks the active-high sync polarity.
module tb_vga_timing_controller;

   localparam int HA = 8, HF = 2, HS = 3, HB = 2;   // h: active 0..7, sync 10..12, total 15
   localparam int VA = 6, VF = 1, VS = 2, VB = 1;   // v: active 0..5, sync 7..8, total 10

   logic clk = 1'b0;
   logic rst, ce, en;
   logic hs, vs, de, ls, fs, run;
   logic [10:0] px;
   logic [9:0]  py;
   logic hs_hi, vs_hi, de_hi, ls_hi, fs_hi, run_hi;
   logic [10:0] px_hi;
   logic [9:0]  py_hi;

   always #5 clk = ~clk;

   vga_timing_controller #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .H_COUNTER_SIZE(11), .V_COUNTER_SIZE(10), .SYNC_ACTIVE_LOW(1)) dut (
      .control_clock(clk), .reset(rst), .pixel_ce(ce), .enable(en),
      .h_sync(hs), .v_sync(vs), .display_enable(de), .pixel_x(px), .pixel_y(py),
      .line_start(ls), .frame_start(fs), .running(run));

   vga_timing_controller #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .H_COUNTER_SIZE(11), .V_COUNTER_SIZE(10), .SYNC_ACTIVE_LOW(0)) dut_hi (
      .control_clock(clk), .reset(rst), .pixel_ce(ce), .enable(en),
      .h_sync(hs_hi), .v_sync(vs_hi), .display_enable(de_hi), .pixel_x(px_hi), .pixel_y(py_hi),
      .line_start(ls_hi), .frame_start(fs_hi), .running(run_hi));

   typedef struct {
      logic rst, ce, en;
      logic e_run;
      int   e_h, e_v;
      logic e_hs, e_vs, e_de, e_ls, e_fs;
   } vec_t;

   int n_chk = 0, n_fail = 0;
   int ms = 0, mh = 0, mv = 0;   // reference position: ms 0=idle 1=run 2=stopping
   logic mls = 1'b0, mfs = 1'b0;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic check(input string name, input logic e_run, input int e_h, input int e_v,
                        input logic e_hs, input logic e_vs, input logic e_de,
                        input logic e_ls, input logic e_fs);
      n_chk++;
      if (run !== e_run || int'(px) != e_h || int'(py) != e_v || hs !== e_hs || vs !== e_vs ||
          de !== e_de || ls !== e_ls || fs !== e_fs || hs_hi !== ~e_hs || vs_hi !== ~e_vs ||
          de_hi !== e_de || int'(px_hi) != e_h) begin
         n_fail++;
         $display("FAIL %s t=%0t: got run=%b x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b hs_hi=%b vs_hi=%b; want run=%b x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b hs_hi=%b vs_hi=%b",
                  name, $time, run, px, py, hs, vs, de, ls, fs, hs_hi, vs_hi,
                  e_run, e_h, e_v, e_hs, e_vs, e_de, e_ls, e_fs, ~e_hs, ~e_vs);
      end
   endtask

   task automatic expect_eq(input string name, input int got, input int want);
      n_chk++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic adv();
      if (mh == 14) begin
         mh = 0; mls = 1'b1;
         if (mv == 9) begin mv = 0; mfs = 1'b1; end else mv++;
      end else mh++;
   endtask

   // One clock: update the reference for the current inputs, clock, then compare
   task automatic cyc(input string name);
      logic r;
      if (rst) begin ms = 0; mh = 0; mv = 0; mls = 1'b0; mfs = 1'b0; end
      else begin
         mls = 1'b0; mfs = 1'b0;
         case (ms)
            0: if (en && ce) begin ms = 1; mls = 1'b1; mfs = 1'b1; end
            1: begin if (ce) adv(); if (!en) ms = 2; end
            default: if (!en && ce && mh == 14 && mv == 9) begin ms = 0; mh = 0; mv = 0; end
                     else begin if (ce) adv(); if (en) ms = 1; end
         endcase
      end
      tick();
      r = (ms != 0);
      check(name, r, mh, mv, !(r && mh >= 10 && mh <= 12), !(r && mv >= 7 && mv <= 8),
            r && mh < 8 && mv < 6, mls, mfs);
   endtask

   task automatic run_to(input int th, input int tv);
      for (int i = 0; i < 3000; i++) begin
         if (mh == th && mv == tv && ms != 0) return;
         cyc("run_to");
      end
      expect_eq("run_to_timeout", 0, 1);
   endtask

   vec_t vt[9];

   initial begin
      int fcnt, lcnt, lowrun, gaps;
      rst = 1'b1; ce = 1'b0; en = 1'b0;

      //          rst   ce    en    run   h  v  hs    vs    de    ls    fs
      vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vt[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

      for (int i = 0; i < 9; i++) begin
         rst = vt[i].rst; ce = vt[i].ce; en = vt[i].en;
         tick();
         check($sformatf("vec%0d", i), vt[i].e_run, vt[i].e_h, vt[i].e_v, vt[i].e_hs,
               vt[i].e_vs, vt[i].e_de, vt[i].e_ls, vt[i].e_fs);
      end
      ms = 1; mh = 0; mv = 0;

      // Free run from (0,0): strobes every 15 / 150 clocks
      fcnt = 0; lcnt = 0;
      for (int k = 1; k <= 320; k++) begin
         cyc("free_run");
         if (fs) fcnt++;
         if (ls) lcnt++;
      end
      expect_eq("frame_start_count", fcnt, 2);
      expect_eq("line_start_count", lcnt, 21);

      // Drop enable mid-frame: the frame completes, then idle without a frame_start
      run_to(5, 3);
      en = 1'b0; fcnt = 0;
      for (int i = 0; i < 500 && ms != 0; i++) begin
         cyc("stopping");
         if (fs) fcnt++;
      end
      expect_eq("stop_no_frame_start", fcnt, 0);
      expect_eq("stop_running", int'(run), 0);
      repeat (5) cyc("idle_hold");

      // Re-request before the frame ends: no stop at the boundary
      en = 1'b1;
      cyc("restart");
      run_to(5, 3);
      en = 1'b0;
      run_to(0, 6);
      en = 1'b1;
      run_to(0, 0);
      expect_eq("resume_running", int'(run), 1);
      expect_eq("resume_frame_start", int'(fs), 1);

      // pixel_ce every 4th clock: h_sync low runs are 3 ticks = 12 clocks
      lowrun = 0; gaps = 0;
      for (int i = 0; i < 640; i++) begin
         ce = (i % 4 == 0);
         cyc("ce_div4");
         if (!hs) lowrun++;
         else if (lowrun > 0) begin
            expect_eq("hsync_width_div4", lowrun, 12);
            lowrun = 0; gaps++;
         end
      end
      expect_eq("hsync_pulses_seen", int'(gaps > 5), 1);

      // Reset while both syncs are active
      ce = 1'b1;
      run_to(11, 8);
      expect_eq("pre_reset_hsync", int'(hs), 0);
      expect_eq("pre_reset_vsync_hi", int'(vs_hi), 1);
      rst = 1'b1;
      cyc("reset_mid_sync");
      rst = 1'b0; en = 1'b0;
      repeat (3) cyc("post_reset_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, want finish before 2000000");
      $fatal(1);
   end

endmodule

// File: doc/vga_timing_controller.md
Name: vga_timing_controller

Overview:
- Sequences the VGA raster. Owns one horizontal and one vertical counter and generates h_sync, v_sync, display enable, pixel coordinates and frame/line strobes.
- Run/stop FSM: the scan starts on request and stops only on a frame boundary, so the monitor never sees a truncated frame.
- Sits between the clock/reset block and the pixel/framebuffer logic. It replaces the free-running per-axis sync generators.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_COUNTER_SIZE, 11, horizontal counter width; must hold H_TOTAL-1
- V_COUNTER_SIZE, 10, vertical counter width; must hold V_TOTAL-1
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses driven low, 0 = driven high

Ports:
- control_clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pixel_ce  in  1  pixel-rate clock enable; counters advance only when high
- enable  in  1  run request level
- h_sync  out  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- v_sync  out  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- display_enable  out  1  high while the counters are inside the active region
- pixel_x  out  H_COUNTER_SIZE  current horizontal count
- pixel_y  out  V_COUNTER_SIZE  current vertical count
- line_start  out  1  one-control_clock pulse when h_count becomes 0
- frame_start  out  1  one-control_clock pulse when (h,v) becomes (0,0)
- running  out  1  high in RUN and STOPPING states

Behaviour:
- Derived constants: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Region layout per axis: [0, ACTIVE-1] active, then front porch, then sync, then back porch.
  - h_sync is asserted for h in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1], i.e. 656..751.
  - v_sync is asserted for v in [490, 491].
  - display_enable = (h < H_ACTIVE) && (v < V_ACTIVE).
- All outputs are registered and cycle-aligned with the pixel_x/pixel_y values they describe. Outputs are decoded from the next-count value, giving zero skew between coordinates and decode.
- Counter step, on a control_clock edge with pixel_ce=1 in RUN or STOPPING:
  - h wraps from H_TOTAL-1 to 0; otherwise h increments.
  - v increments only when h wraps. v wraps from V_TOTAL-1 to 0 together with h.
  - With pixel_ce=0, all state and outputs hold, except that strobes clear.
- FSM states:
  - IDLE: counters held at 0, syncs at the inactive level, display_enable=0, strobes 0, running=0.
  - IDLE -> RUN: on a cycle with enable=1 and pixel_ce=1. On that cycle the counters stay at (0,0), frame_start=1 and line_start=1 pulse, and running goes 1.
  - RUN -> STOPPING: on any cycle with enable=0. Scanning continues unchanged.
  - STOPPING -> RUN: if enable=1 again before the frame ends. No discontinuity, no extra frame_start.
  - STOPPING -> IDLE: on the pixel_ce cycle where (h,v) = (H_TOTAL-1, V_TOTAL-1). Counters go to 0, no frame_start, and outputs take IDLE values.
- Strobes:
  - line_start and frame_start are exactly one control_clock cycle wide, even if pixel_ce stays high continuously.
  - frame_start implies line_start in the same cycle.
- Reset: synchronous, dominates everything.
  - Next edge: FSM=IDLE, counters=0, h_sync/v_sync inactive (1 if SYNC_ACTIVE_LOW), display_enable=0, strobes=0, running=0.
  - Reset mid-line or mid-frame aborts immediately; no frame completion is required.
- Simultaneous events:
  - reset beats enable and pixel_ce.
  - A wrap cycle with enable=0 in RUN wraps normally, then enters STOPPING; the full next frame is completed before IDLE.

Test Plan:
- Reset, enable=1, pixel_ce=1 continuously -> running=1 one cycle after the first enabled edge; frame_start period = 420000 cycles; line_start period = 800 cycles.
- Free run, sample one line -> display_enable high for h 0..639; h_sync low for exactly 96 pixel_ce cycles starting at h=656; pixel_x wraps 799->0.
- Full frame -> v_sync low only for lines 490..491 (1600 cycles); display_enable low for all of lines 480..524; pixel_y wraps 524->0 together with pixel_x 799->0.
- Drop enable at (h=100, v=200) -> scanning continues to (799,524), then IDLE with counters (0,0), running=0, no frame_start; reassert at v=300 instead -> no stop, frame continues.
- pixel_ce high every 4th cycle -> counters step only on those cycles; strobes still 1 cycle wide; h_sync width = 96 pixel_ce ticks (384 clocks).
- Assert reset at (h=700, v=491, syncs active) -> next edge: syncs inactive, counters 0, IDLE; with SYNC_ACTIVE_LOW=0, syncs idle low and pulse high.
